dbp_dbx_enc_dbuf: RTL and testbench

//  Delta + bit-plane transposition front end of the EBPC encoder, next generation.
//  - Takes a stream of signed words and groups them into blocks of BLOCK_SIZE.
//  - Per block, emits the base word plus DATA_W+1 delta bit-planes (DBPs).
//  - Double-buffered: a new block fills while the previous one waits downstream, giving 1 word/cycle.
//  - Flush pads a partial block. Sits between the input stream and the DBP/DBX coder stage.

---
 rtl/dbp_dbx_enc_dbuf_if.sv | 39 +++
 rtl/dbp_dbx_enc_dbuf.sv | 188 ++++++++++++++++++
 tb/tb_dbp_dbx_enc_dbuf.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dbp_dbx_enc_dbuf_if.sv
// Stream interface of the delta/bit-plane encoder front end: word input side and block output side.
// Raw-mode tag signals exist only when DBP_ENC_RAW_MODE_EN is defined.
interface dbp_dbx_enc_dbuf_if #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8
);
    logic [DATA_W-1:0]                       data_i;
    logic                                    vld_i;
    logic                                    flush_i;
    logic                                    rdy_o;
    logic [DATA_W-1:0]                       base_o;
    logic [(DATA_W+1)*(BLOCK_SIZE-1)-1:0]    dbp_o;
    logic                                    vld_o;
    logic                                    rdy_i;
    logic                                    flush_o;
    logic                                    idle_o;
`ifdef DBP_ENC_RAW_MODE_EN
    logic                                    raw_i;
    logic                                    raw_o;

    modport slave (
        input  data_i, vld_i, flush_i, rdy_i, raw_i,
        output rdy_o, base_o, dbp_o, vld_o, flush_o, idle_o, raw_o
    );
    modport master (
        output data_i, vld_i, flush_i, rdy_i, raw_i,
        input  rdy_o, base_o, dbp_o, vld_o, flush_o, idle_o, raw_o
    );
`else
    modport slave (
        input  data_i, vld_i, flush_i, rdy_i,
        output rdy_o, base_o, dbp_o, vld_o, flush_o, idle_o
    );
    modport master (
        output data_i, vld_i, flush_i, rdy_i,
        input  rdy_o, base_o, dbp_o, vld_o, flush_o, idle_o
    );
`endif
endinterface

// File: rtl/dbp_dbx_enc_dbuf.sv
// Delta + bit-plane transposition front end of the EBPC encoder with a double-buffered output block.
// Optional raw (non-delta) block mode is enabled by defining DBP_ENC_RAW_MODE_EN.
module dbp_dbx_enc_dbuf #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dbp_dbx_enc_dbuf_if.slave     bus
);
    localparam int ND    = BLOCK_SIZE - 1;
    localparam int DW1   = DATA_W + 1;
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ND);

    typedef enum logic [2:0] {EMPTY, FILL, FULL, PAD, FLUSH_WAIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0]  prev_q, base_q;
    logic [DW1-1:0]     sh_q [ND];
    logic [DW1-1:0]     sh_d [ND];
    logic               raw_q;
    logic               out_vld_q, out_raw_q;
    logic [DATA_W-1:0]  out_base_q;
    logic [DW1*ND-1:0]  out_dbp_q, dbp_pack;
    logic               rdy, in_hs, out_free, xfer, shift_en, flush_pulse;
    logic [DW1-1:0]     shift_val;

    assign rdy      = (state_q == EMPTY) || (state_q == FILL);
    assign in_hs    = bus.vld_i && rdy;
    assign out_free = !out_vld_q || bus.rdy_i;
    assign shift_en = ((state_q == FILL) && in_hs) || (state_q == PAD);

    // Deltas are formed one bit wider than the data so they can never overflow.
    always_comb begin
        shift_val = '0;
        if (state_q == FILL) begin
            if (raw_q)
                shift_val = {bus.data_i[DATA_W-1], bus.data_i};
            else
                shift_val = {bus.data_i[DATA_W-1], bus.data_i} - {prev_q[DATA_W-1], prev_q};
        end
    end

    always_comb begin
        for (int i = 0; i < ND; i++) sh_d[i] = sh_q[i];
        if (shift_en) begin
            for (int i = 0; i < ND - 1; i++) sh_d[i] = sh_q[i+1];
            sh_d[ND-1] = shift_val;
        end
    end

    // The oldest delta ends up in sh_d[0] and lands in the MSB of each plane.
    always_comb begin
        dbp_pack = '0;
        for (int p = 0; p < DW1; p++)
            for (int j = 0; j < ND; j++)
                dbp_pack[p*ND + j] = sh_d[ND-1-j][p];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        xfer         = 1'b0;
        flush_pulse  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    cnt_d   = CNT_W'(1);
                    state_d = bus.flush_i ? PAD : FILL;
                end else if (bus.flush_i) begin
                    if (!out_vld_q) flush_pulse = 1'b1;
                    else            state_d     = FLUSH_WAIT;
                end
            end
            FILL: begin
                if (in_hs && (cnt_q == LAST_CNT)) begin
                    if (out_free) begin
                        xfer    = 1'b1;
                        cnt_d   = '0;
                        state_d = bus.flush_i ? FLUSH_WAIT : EMPTY;
                    end else begin
                        cnt_d        = cnt_q + 1'b1;
                        state_d      = FULL;
                        flush_pend_d = bus.flush_i;
                    end
                end else begin
                    if (in_hs) cnt_d = cnt_q + 1'b1;
                    if (bus.flush_i) state_d = PAD;
                end
            end
            FULL: begin
                if (out_free) begin
                    xfer         = 1'b1;
                    cnt_d        = '0;
                    state_d      = flush_pend_q ? FLUSH_WAIT : EMPTY;
                    flush_pend_d = 1'b0;
                end
            end
            PAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    if (out_free) begin
                        xfer    = 1'b1;
                        cnt_d   = '0;
                        state_d = FLUSH_WAIT;
                    end else begin
                        state_d      = FULL;
                        flush_pend_d = 1'b1;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (!out_vld_q) begin
                    flush_pulse = 1'b1;
                    state_d     = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            base_q <= '0;
            raw_q  <= 1'b0;
            for (int i = 0; i < ND; i++) sh_q[i] <= '0;
        end else begin
            if (in_hs) prev_q <= bus.data_i;
            if (in_hs && (state_q == EMPTY)) begin
                base_q <= bus.data_i;
`ifdef DBP_ENC_RAW_MODE_EN
                raw_q  <= bus.raw_i;
`else
                raw_q  <= 1'b0;
`endif
            end
            for (int i = 0; i < ND; i++) sh_q[i] <= sh_d[i];
        end
    end

    // Loading on the same edge a held block drains keeps the output bubble-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_raw_q  <= 1'b0;
            out_base_q <= '0;
            out_dbp_q  <= '0;
        end else if (xfer) begin
            out_vld_q  <= 1'b1;
            out_raw_q  <= raw_q;
            out_base_q <= base_q;
            out_dbp_q  <= dbp_pack;
        end else if (bus.rdy_i) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign bus.rdy_o   = rdy;
    assign bus.vld_o   = out_vld_q;
    assign bus.base_o  = out_base_q;
    assign bus.dbp_o   = out_dbp_q;
    assign bus.flush_o = flush_pulse;
    assign bus.idle_o  = (state_q == EMPTY) && !out_vld_q && !bus.vld_i;
`ifdef DBP_ENC_RAW_MODE_EN
    assign bus.raw_o   = out_raw_q;
`else
    logic unused_raw;
    assign unused_raw = out_raw_q;
`endif

endmodule

// File: tb/tb_dbp_dbx_enc_dbuf.sv
// Self-checking bench for dbp_dbx_enc_dbuf: directed cases plus randomized traffic against a block-level model.
module tb_dbp_dbx_enc_dbuf;
    localparam int DW   = 8;
    localparam int BS   = 8;
    localparam int ND   = BS - 1;
    localparam int DBPW = (DW + 1) * ND;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    dbp_dbx_enc_dbuf_if #(.DATA_W(DW), .BLOCK_SIZE(BS)) bus ();

    dbp_dbx_enc_dbuf #(.DATA_W(DW), .BLOCK_SIZE(BS)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int flush_exp = 0;
    int flush_seen = 0;
    int vld_seen = 0;
    int rdy_drops = 0;
    logic [DW-1:0]   cur_words [$];
    logic [DW-1:0]   exp_base  [$];
    logic [DBPW-1:0] exp_dbp   [$];
    logic            obs_vld, obs_rdy;
    logic [DW-1:0]   obs_base;
    logic [DBPW-1:0] obs_dbp;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Block model: base word, then plain integer differences, padded with zero deltas.
    task automatic emitBlock();
        logic [DBPW-1:0] d;
        int delta;
        d = '0;
        for (int k = 1; k <= ND; k++) begin
            delta = (k < cur_words.size()) ?
                    int'($signed(cur_words[k])) - int'($signed(cur_words[k-1])) : 0;
            for (int p = 0; p <= DW; p++)
                d[p*ND + ND - k] = ((delta >>> p) & 1) != 0;
        end
        exp_base.push_back(cur_words[0]);
        exp_dbp.push_back(d);
        cur_words.delete();
    endtask

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        logic [DW-1:0]   b;
        logic [DBPW-1:0] p;
        @(negedge clk_i);
        bus.vld_i   = v;
        bus.data_i  = d;
        bus.flush_i = f;
        bus.rdy_i   = r;
        #4;
        obs_vld  = bus.vld_o;
        obs_rdy  = bus.rdy_o;
        obs_base = bus.base_o;
        obs_dbp  = bus.dbp_o;
        if (bus.vld_o) vld_seen++;
        if (!bus.rdy_o) rdy_drops++;
        if (bus.vld_o && r) begin
            if (exp_base.size() == 0) begin
                checkOutput("unexpected_block", 64'd1, 64'd0);
            end else begin
                b = exp_base.pop_front();
                p = exp_dbp.pop_front();
                checkOutput("base_o", 64'(bus.base_o), 64'(b));
                checkOutput("dbp_o", 64'(bus.dbp_o), 64'(p));
            end
        end
        if (bus.flush_o) begin
            flush_seen++;
            checkOutput("flush_with_vld_o", 64'(bus.vld_o), 64'd0);
        end
        if (v && bus.rdy_o) begin
            cur_words.push_back(d);
            if (cur_words.size() == BS) emitBlock();
        end
        if (f && bus.rdy_o) begin
            if (cur_words.size() > 0) emitBlock();
            flush_exp++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_vld_o"},   64'(bus.vld_o),   64'd0);
        checkOutput({tag, "_flush_o"}, 64'(bus.flush_o), 64'd0);
        checkOutput({tag, "_base_o"},  64'(bus.base_o),  64'd0);
        checkOutput({tag, "_dbp_o"},   64'(bus.dbp_o),   64'd0);
        checkOutput({tag, "_idle_o"},  64'(bus.idle_o),  64'd1);
        checkOutput({tag, "_rdy_o"},   64'(bus.rdy_o),   64'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int fl_before;
        int idx;
        logic [DW-1:0] words [16];
        bus.vld_i   = 1'b0;
        bus.data_i  = '0;
        bus.flush_i = 1'b0;
        bus.rdy_i   = 1'b0;
`ifdef DBP_ENC_RAW_MODE_EN
        bus.raw_i   = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        #4;
        checkResetValues("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] ramp 10..17");
        for (int i = 0; i < BS; i++) applyStimulus(1'b1, DW'(10 + i), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ramp_latency_vld", 64'(obs_vld), 64'd1);
        checkOutput("ramp_base", 64'(obs_base), 64'd10);
        checkOutput("ramp_dbp", 64'(obs_dbp), 64'h7F);
        drain(2);

        $display("[TB] extreme delta 127,-128");
        applyStimulus(1'b1, 8'd127, 1'b0, 1'b1);
        for (int i = 1; i < BS; i++) applyStimulus(1'b1, 8'h80, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("extreme_base", 64'(obs_base), 64'd127);
        checkOutput("extreme_dbp", 64'(obs_dbp), 64'h4000_0000_0000_0040);
        drain(2);

        $display("[TB] back-to-back blocks");
        rdy_drops = 0;
        vld_seen  = 0;
        for (int i = 0; i < 3 * BS; i++) applyStimulus(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b1);
        drain(2);
        checkOutput("b2b_rdy_drops", 64'(rdy_drops), 64'd0);
        checkOutput("b2b_vld_cycles", 64'(vld_seen), 64'd3);

        $display("[TB] backpressure over two blocks");
        for (int i = 0; i < 16; i++) words[i] = DW'($urandom_range(0, 255));
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(idx < 16, words[idx % 16], 1'b0, 1'b0);
            if (idx < 16 && obs_rdy) idx++;
        end
        checkOutput("bp_rdy_o_low", 64'(obs_rdy), 64'd0);
        checkOutput("bp_words_taken", 64'(idx), 64'd16);
        checkOutput("bp_block1_held", 64'(obs_base), 64'(words[0]));
        drain(6);
        checkOutput("bp_all_out", 64'(exp_base.size()), 64'd0);

        $display("[TB] partial block flush");
        fl_before = flush_seen;
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd7, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        drain(BS + 6);
        checkOutput("flush_pulses", 64'(flush_seen - fl_before), 64'd1);
        checkOutput("flush_idle", 64'(bus.idle_o), 64'd1);

        $display("[TB] flush with nothing buffered");
        fl_before = flush_seen;
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("empty_flush_comb", 64'(flush_seen - fl_before), 64'd1);

        $display("[TB] reset mid-block");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(i + 40), 1'b0, 1'b1);
        @(negedge clk_i);
        bus.vld_i = 1'b0;
        bus.flush_i = 1'b0;
        rst_ni = 1'b0;
        #4;
        checkResetValues("midreset");
        cur_words.delete();
        exp_base.delete();
        exp_dbp.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < BS; i++) applyStimulus(1'b1, DW'(8'hA0 + 3 * i), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("post_reset_base", 64'(obs_base), 64'hA0);
        drain(2);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++)
            applyStimulus($urandom_range(0, 99) < 70, DW'($urandom_range(0, 255)),
                          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
        drain(30);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        drain(30);
        checkOutput("final_leftover_words", 64'(cur_words.size()), 64'd0);
        checkOutput("final_blocks_pending", 64'(exp_base.size()), 64'd0);
        checkOutput("final_flush_count", 64'(flush_seen), 64'(flush_exp));
        checkOutput("final_idle", 64'(bus.idle_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
